// File: rtl/fifo_word_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_packer_if
// Description : Upstream deq, downstream enq, flush and status bundle for the
//               32->64 bit word packer.
// Revision    : 1.0  initial release
// ============================================================================
interface fifo_word_packer_if #(
    parameter int CNT_W = 16
);
    logic             in_first__RDY;
    logic [31:0]      in_first;
    logic             in_deq__RDY;
    logic             in_deq__ENA;
    logic             out_enq__RDY;
    logic             out_enq__ENA;
    logic [63:0]      out_enq_v;
    logic             flush__RDY;
    logic             flush__ENA;
    logic             busy;
    logic [CNT_W-1:0] pair_count;

    // Environment side: supplies upstream data, downstream ready and flush.
    modport master (
        output in_first__RDY, in_first, in_deq__RDY, out_enq__RDY, flush__ENA,
        input  in_deq__ENA, out_enq__ENA, out_enq_v, flush__RDY, busy, pair_count
    );

    // Packer side.
    modport slave (
        input  in_first__RDY, in_first, in_deq__RDY, out_enq__RDY, flush__ENA,
        output in_deq__ENA, out_enq__ENA, out_enq_v, flush__RDY, busy, pair_count
    );
endinterface
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_packer
// Description : Drains a 32-bit FIFO stage and emits packed 64-bit words.
// Revision    : 1.0  initial release
// ============================================================================
module fifo_word_packer #(
    parameter bit          FIRST_IN_HIGH = 1'b0,
    parameter logic [31:0] PAD_VALUE     = 32'h0,
    parameter int          CNT_W         = 16
) (
    input  wire logic        CLK,
    input  wire logic        nRST,
    fifo_word_packer_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      hold_reg;
    logic [63:0]      out_reg;
    logic [CNT_W-1:0] pair_count_reg;

    logic             take;
    logic             deq_ena;
    logic             enq_ena;
    logic             load_hold;
    logic             load_out;
    logic             cnt_inc;
    logic [31:0]      second_word;

    // a is the older word of the pair.
    function automatic logic [63:0] pack(input logic [31:0] a, input logic [31:0] b);
        return FIRST_IN_HIGH ? {a, b} : {b, a};
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset gates the deq strobe so upstream is never popped while held in reset.
    always_comb begin
        state_nxt   = state;
        load_hold   = 1'b0;
        load_out    = 1'b0;
        cnt_inc     = 1'b0;
        second_word = bus.in_first;
        take        = bus.in_first__RDY & bus.in_deq__RDY;
        deq_ena     = take & ~bus.flush__ENA & ((state != FULL) | bus.out_enq__RDY) & nRST;
        enq_ena     = (state == FULL) & bus.out_enq__RDY;

        case (state)
            EMPTY: begin
                if (deq_ena) begin
                    load_hold = 1'b1;
                    state_nxt = HALF;
                end
            end
            HALF: begin
                if (bus.flush__ENA) begin
                    load_out    = 1'b1;
                    second_word = PAD_VALUE;
                    state_nxt   = FULL;
                end else if (deq_ena) begin
                    load_out  = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (enq_ena) begin
                    cnt_inc = 1'b1;
                    if (deq_ena) begin
                        load_hold = 1'b1;
                        state_nxt = HALF;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hold_reg       <= '0;
            out_reg        <= '0;
            pair_count_reg <= '0;
        end else begin
            if (load_hold) begin
                hold_reg <= bus.in_first;
            end
            if (load_out) begin
                out_reg <= pack(hold_reg, second_word);
            end
            if (cnt_inc) begin
                pair_count_reg <= pair_count_reg + 1'b1;
            end
        end
    end

    assign bus.in_deq__ENA  = deq_ena;
    assign bus.out_enq__ENA = enq_ena;
    assign bus.out_enq_v    = out_reg;
    assign bus.flush__RDY   = (state == HALF);
    assign bus.busy         = (state != EMPTY);
    assign bus.pair_count   = pair_count_reg;
endmodule
`default_nettype wire
